// File: rtl/score_display_sched.sv
// rtl/score_display_sched.sv - shares one two-digit 7-seg driver between player A and B scores
// Optional blank-flash during hold: define SCORE_DISPLAY_SCHED_FLASH_EN.
module score_display_sched #(
    parameter int DWELL_CYCLES = 1000,
    parameter int HOLD_CYCLES  = 3000,
    parameter int FLASH_CYCLES = 250,
    parameter int CNT_W        = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] a_tens_i,
    input  logic [3:0] a_ones_i,
    input  logic [3:0] b_tens_i,
    input  logic [3:0] b_ones_i,
    input  logic       upd_a_i,
    input  logic       upd_b_i,
    output logic [3:0] tens_o,
    output logic [3:0] ones_o,
    output logic       sel_o,
    output logic       hold_o,
    output logic       blank_o
);

    typedef enum logic [1:0] {SHOW_A, SHOW_B, HOLD_A, HOLD_B} state_t;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);

    // Illegal parameter sets elaborate a visibly named block so they stand out in the hierarchy.
    if (FLASH_CYCLES < 1) begin : g_cfg_error_flash_cycles
    end
    if ((DWELL_CYCLES - 1) >= (1 << CNT_W) || (HOLD_CYCLES - 1) >= (1 << CNT_W)) begin : g_cfg_error_cnt_w
    end

    state_t           state;
    state_t           nxt_state;
    logic [CNT_W-1:0] cnt;
    logic             pend_a, pend_b;
    logic             nxt_pend_a, nxt_pend_b;
    logic             rehold;
    logic             cnt_clr;
    logic             dwell_last, hold_last;
    logic             nxt_is_b, nxt_is_hold;

    assign dwell_last  = (cnt == DWELL_LAST);
    assign hold_last   = (cnt == HOLD_LAST);
    assign cnt_clr     = rehold || (nxt_state != state);
    assign nxt_is_b    = (nxt_state == SHOW_B) || (nxt_state == HOLD_B);
    assign nxt_is_hold = (nxt_state == HOLD_A) || (nxt_state == HOLD_B);

    // Next-state: updates take priority over rotation/expiry; A wins ties, B waits on pend_b.
    always_comb begin
        nxt_state  = state;
        nxt_pend_a = pend_a;
        nxt_pend_b = pend_b;
        rehold     = 1'b0;
        case (state)
            SHOW_A, SHOW_B: begin
                if (upd_a_i) begin
                    nxt_state  = HOLD_A;
                    nxt_pend_b = upd_b_i;
                end else if (upd_b_i) begin
                    nxt_state = HOLD_B;
                end else if (dwell_last) begin
                    nxt_state = (state == SHOW_A) ? SHOW_B : SHOW_A;
                end
            end
            HOLD_A: begin
                if (upd_a_i) begin
                    rehold = 1'b1;
                    if (upd_b_i) nxt_pend_b = 1'b1;
                end else if (upd_b_i) begin
                    if (hold_last) begin
                        nxt_state  = HOLD_B;
                        nxt_pend_b = 1'b0;
                    end else begin
                        nxt_pend_b = 1'b1;
                    end
                end else if (hold_last) begin
                    nxt_state  = pend_b ? HOLD_B : SHOW_B;
                    nxt_pend_b = 1'b0;
                end
            end
            HOLD_B: begin
                if (upd_b_i) begin
                    rehold = 1'b1;
                    if (upd_a_i) nxt_pend_a = 1'b1;
                end else if (upd_a_i) begin
                    if (hold_last) begin
                        nxt_state  = HOLD_A;
                        nxt_pend_a = 1'b0;
                    end else begin
                        nxt_pend_a = 1'b1;
                    end
                end else if (hold_last) begin
                    nxt_state  = pend_a ? HOLD_A : SHOW_A;
                    nxt_pend_a = 1'b0;
                end
            end
            default: nxt_state = SHOW_A;
        endcase
    end

    // State, phase counter, pending flags and the display registers driven from the state being entered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= SHOW_A;
            cnt    <= '0;
            pend_a <= 1'b0;
            pend_b <= 1'b0;
            tens_o <= 4'd0;
            ones_o <= 4'd0;
            sel_o  <= 1'b0;
            hold_o <= 1'b0;
        end else begin
            state  <= nxt_state;
            cnt    <= cnt_clr ? '0 : cnt + 1'b1;
            pend_a <= nxt_pend_a;
            pend_b <= nxt_pend_b;
            tens_o <= nxt_is_b ? b_tens_i : a_tens_i;
            ones_o <= nxt_is_b ? b_ones_i : a_ones_i;
            sel_o  <= nxt_is_b;
            hold_o <= nxt_is_hold;
        end
    end

`ifdef SCORE_DISPLAY_SCHED_FLASH_EN
    localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_CYCLES - 1);

    logic [CNT_W-1:0] flash_cnt;

    // Blank toggles every FLASH_CYCLES inside a hold, restarting visible on entry, re-hold or transition.
    always_ff @(posedge clk_i) begin
        if (rst_i || !nxt_is_hold || cnt_clr) begin
            flash_cnt <= '0;
            blank_o   <= 1'b0;
        end else if (flash_cnt == FLASH_LAST) begin
            flash_cnt <= '0;
            blank_o   <= ~blank_o;
        end else begin
            flash_cnt <= flash_cnt + 1'b1;
        end
    end
`else
    assign blank_o = 1'b0;
`endif

endmodule

// File: tb/tb_score_display_sched.sv
// tb/tb_score_display_sched.sv - randomized self-checking bench for score_display_sched
module tb_score_display_sched;

    localparam int DWELL = 4;
    localparam int HOLD  = 8;
    localparam int FLASH = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] a_tens = 4'd0, a_ones = 4'd0, b_tens = 4'd0, b_ones = 4'd0;
    logic       upd_a = 1'b0, upd_b = 1'b0;
    logic [3:0] tens, ones;
    logic       sel, hold, blank;

    int checks = 0;
    int errors = 0;

    score_display_sched #(
        .DWELL_CYCLES(DWELL),
        .HOLD_CYCLES (HOLD),
        .FLASH_CYCLES(FLASH),
        .CNT_W       (4)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .a_tens_i(a_tens),
        .a_ones_i(a_ones),
        .b_tens_i(b_tens),
        .b_ones_i(b_ones),
        .upd_a_i (upd_a),
        .upd_b_i (upd_b),
        .tens_o  (tens),
        .ones_o  (ones),
        .sel_o   (sel),
        .hold_o  (hold),
        .blank_o (blank)
    );

    always #5 clk = ~clk;

    wire [10:0] got = {tens, ones, sel, hold, blank};

    // Reference model: which player is shown, whether it is a hold, time spent there, and who is waiting.
    int         m_player  = 0;
    int         m_holding = 0;
    int         m_elapsed = 0;
    bit         m_pend [2];
    logic [10:0] exp_vec  = '0;

    task automatic model_enter(input int holding, input int player);
        m_holding = holding;
        m_player  = player;
        m_elapsed = 0;
    endtask

    task automatic model_step(input logic ua, input logic ub);
        int  other;
        bit  own_upd, oth_upd, last;
        logic exp_blank;
        if (rst) begin
            m_player = 0; m_holding = 0; m_elapsed = 0;
            m_pend[0] = 0; m_pend[1] = 0;
            exp_vec = '0;
            return;
        end
        other   = 1 - m_player;
        own_upd = (m_player == 1) ? ub : ua;
        oth_upd = (m_player == 1) ? ua : ub;
        last    = (m_elapsed == (m_holding ? HOLD : DWELL) - 1);
        if (!m_holding) begin
            if (ua) begin
                model_enter(1, 0);
                m_pend[1] = ub;
            end else if (ub) model_enter(1, 1);
            else if (last)   model_enter(0, other);
            else             m_elapsed++;
        end else begin
            if (own_upd) begin
                m_elapsed = 0;
                if (oth_upd) m_pend[other] = 1;
            end else if (oth_upd && last) begin
                m_pend[other] = 0;
                model_enter(1, other);
            end else if (oth_upd) begin
                m_pend[other] = 1;
                m_elapsed++;
            end else if (last) begin
                if (m_pend[other]) begin
                    m_pend[other] = 0;
                    model_enter(1, other);
                end else model_enter(0, other);
            end else m_elapsed++;
        end
`ifdef SCORE_DISPLAY_SCHED_FLASH_EN
        exp_blank = m_holding ? logic'((m_elapsed / FLASH) % 2) : 1'b0;
`else
        exp_blank = 1'b0;
`endif
        exp_vec = {(m_player == 1) ? b_tens : a_tens,
                   (m_player == 1) ? b_ones : a_ones,
                   logic'(m_player == 1), logic'(m_holding == 1), exp_blank};
    endtask

    // One clock: present pulses, let the edge happen, advance the model, settle before sampling.
    task automatic tick(input logic ua, input logic ub);
        upd_a = ua;
        upd_b = ub;
        @(posedge clk);
        model_step(ua, ub);
        #1;
        upd_a = 1'b0;
        upd_b = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_tens = 4'($urandom); a_ones = 4'($urandom);
            b_tens = 4'($urandom); b_ones = 4'($urandom);
            tick(1'($urandom), 1'($urandom));
            checks++;
            if (got !== 11'd0) begin
                errors++;
                $display("FAIL reset cyc=%0d got=%h exp=000", i, got);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_rotation();
        int sel_hist [16];
        a_tens = 4'd1; a_ones = 4'd2; b_tens = 4'd3; b_ones = 4'd4;
        for (int i = 0; i < 16; i++) begin
            tick(1'b0, 1'b0);
            sel_hist[i] = sel;
            checks++;
            if (got !== exp_vec) begin
                errors++;
                $display("FAIL rotation cyc=%0d got=%h exp=%h", i, got, exp_vec);
            end
        end
        // first post-reset cycle belongs to SHOW_A already, so A shows 3 more, then B for 4
        checks++;
        if (sel_hist[2] !== 0 || sel_hist[3] !== 1 || sel_hist[6] !== 1 || sel_hist[7] !== 0) begin
            errors++;
            $display("FAIL rotation_period got=%0d%0d%0d%0d exp=0110",
                     sel_hist[2], sel_hist[3], sel_hist[6], sel_hist[7]);
        end
    endtask

    task automatic test_update_b();
        int n_hold = 0;
        tick(1'b1, 1'b0);            // settle into a known state first
        for (int i = 0; i < HOLD; i++) tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (got !== exp_vec) begin
                errors++;
                $display("FAIL update_b cyc=%0d got=%h exp=%h", i, got, exp_vec);
            end
            if (hold && sel) n_hold++;
            tick(1'b0, 1'b0);
        end
        checks++;
        if (n_hold != HOLD) begin
            errors++;
            $display("FAIL update_b_len got=%0d exp=%0d", n_hold, HOLD);
        end
    endtask

    task automatic test_simultaneous();
        int n_a = 0, n_b = 0;
        tick(1'b1, 1'b1);
        for (int i = 0; i < 2 * HOLD + 2; i++) begin
            checks++;
            if (got !== exp_vec) begin
                errors++;
                $display("FAIL simultaneous cyc=%0d got=%h exp=%h", i, got, exp_vec);
            end
            if (hold && !sel) n_a++;
            if (hold && sel)  n_b++;
            if (i == 2 * HOLD) begin
                checks++;
                if (hold !== 1'b0 || sel !== 1'b0) begin
                    errors++;
                    $display("FAIL simultaneous_exit got=%b%b exp=00", hold, sel);
                end
            end
            tick(1'b0, 1'b0);
        end
        checks++;
        if (n_a != HOLD || n_b != HOLD) begin
            errors++;
            $display("FAIL simultaneous_len got=%0d/%0d exp=%0d/%0d", n_a, n_b, HOLD, HOLD);
        end
    endtask

    task automatic test_rehold();
        int n_after = 0;
        tick(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        for (int i = 0; i < HOLD + 2; i++) begin
            checks++;
            if (got !== exp_vec) begin
                errors++;
                $display("FAIL rehold cyc=%0d got=%h exp=%h", i, got, exp_vec);
            end
            if (hold) n_after++;
            tick(1'b0, 1'b0);
        end
        checks++;
        if (n_after != HOLD) begin
            errors++;
            $display("FAIL rehold_len got=%0d exp=%0d", n_after, HOLD);
        end
    endtask

    task automatic test_reset_mid_hold();
        int n_hold = 0;
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);            // pend_a while in HOLD_B
        tick(1'b0, 1'b0);
        rst = 1'b1;
        tick(1'b0, 1'b0);
        rst = 1'b0;
        checks++;
        if (got !== 11'd0) begin
            errors++;
            $display("FAIL reset_mid_hold got=%h exp=000", got);
        end
        for (int i = 0; i < 3 * HOLD; i++) begin
            tick(1'b0, 1'b0);
            if (hold) n_hold++;
            checks++;
            if (got !== exp_vec) begin
                errors++;
                $display("FAIL reset_mid_hold_run cyc=%0d got=%h exp=%h", i, got, exp_vec);
            end
        end
        checks++;
        if (n_hold != 0) begin
            errors++;
            $display("FAIL reset_mid_hold_pend got=%0d exp=0", n_hold);
        end
    endtask

    task automatic test_flash();
        logic [7:0] pat = '0;
        logic [7:0] exp_pat;
`ifdef SCORE_DISPLAY_SCHED_FLASH_EN
        exp_pat = 8'b0011_0011;      // bit 7 = first hold cycle
`else
        exp_pat = 8'b0000_0000;
`endif
        tick(1'b1, 1'b0);
        for (int i = 0; i < HOLD + 2; i++) begin
            if (i < HOLD) pat[7 - i] = blank;
            checks++;
            if (got !== exp_vec) begin
                errors++;
                $display("FAIL flash cyc=%0d got=%h exp=%h", i, got, exp_vec);
            end
            tick(1'b0, 1'b0);
        end
        checks++;
        if (pat !== exp_pat) begin
            errors++;
            $display("FAIL flash_pattern got=%b exp=%b", pat, exp_pat);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                a_tens = 4'($urandom); a_ones = 4'($urandom);   // includes non-BCD codes
            end
            if ($urandom_range(0, 7) == 0) begin
                b_tens = 4'($urandom); b_ones = 4'($urandom);
            end
            rst = ($urandom_range(0, 199) == 0);
            tick($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
            checks++;
            if (got !== exp_vec) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h exp=%h", i, got, exp_vec);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        #1;
        test_reset();
        test_rotation();
        test_update_b();
        test_simultaneous();
        test_rehold();
        test_reset_mid_hold();
        test_flash();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
